// File: rtl/bnn_load_ctrl.sv
// bnn_load_ctrl: streams a pixel/weight image into the BNN register file, then runs one inference.
// Optional watchdog on SYNC_WAIT/INFER enabled by defining BNN_LOAD_TIMEOUT_EN.
module bnn_load_ctrl #(
    parameter int N_PIX    = 784,
    parameter int N_WT     = 72,
    parameter int SYNC_LAT = 2,
    parameter int TIMEOUT  = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       in_valid,
    input  logic       in_pix,
    input  logic       in_wt,
    output logic       in_ready,
    output logic       regs_reset_n,
    output logic       en_wr,
    output logic       d_in_p,
    output logic       d_in_w,
    input  logic       regs_load_done,
    output logic       infer_start,
    input  logic       infer_done,
    input  logic [3:0] infer_class,
    output logic       result_valid,
    output logic [3:0] result_class,
    input  logic       result_ack,
    output logic       busy,
    output logic       err
);
    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, DRAIN, SYNC_WAIT, INFER, RESULT} state_t;
    state_t            state;
    logic [9:0]        cnt;
    logic [SYNC_LAT:0] wr_dly;
    logic              accept;
    logic              expired;
    assign accept = in_valid && in_ready;
    // Write strobe trails the registered data by SYNC_LAT cycles, one slot per cycle.
    assign en_wr  = wr_dly[SYNC_LAT];
`ifdef BNN_LOAD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmr;
    assign expired = (tmr == TW'(TIMEOUT - 1));
    // Restarts on entry to SYNC_WAIT (from DRAIN) and on entry to INFER.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tmr <= '0;
        else
            tmr <= ((state != SYNC_WAIT && state != INFER) || (state == SYNC_WAIT && regs_load_done))
                   ? '0 : tmr + TW'(1);
    end
`else
    assign expired = 1'b0;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            wr_dly       <= '0;
            in_ready     <= 1'b0;
            d_in_p       <= 1'b0;
            d_in_w       <= 1'b0;
            infer_start  <= 1'b0;
            result_valid <= 1'b0;
            result_class <= '0;
            busy         <= 1'b0;
            err          <= 1'b0;
            regs_reset_n <= 1'b0;
        end else begin
            wr_dly       <= (wr_dly << 1) | (SYNC_LAT + 1)'(accept);
            infer_start  <= 1'b0;
            regs_reset_n <= 1'b1;
            if (accept) begin
                d_in_p <= in_pix;
                d_in_w <= (cnt < 10'(N_WT)) && in_wt;
            end
            case (state)
                IDLE: if (start) begin
                    state        <= CLEAR;
                    err          <= 1'b0;
                    busy         <= 1'b1;
                    regs_reset_n <= 1'b0;
                end
                CLEAR: begin
                    state    <= LOAD;
                    cnt      <= '0;
                    in_ready <= 1'b1;
                end
                LOAD: begin
                    if (regs_load_done) err <= 1'b1;
                    if (accept) begin
                        cnt <= cnt + 10'd1;
                        if (cnt == 10'(N_PIX - 1)) begin
                            in_ready <= 1'b0;
                            cnt      <= '0;
                            state    <= DRAIN;
                        end
                    end
                end
                DRAIN: if (cnt == 10'(SYNC_LAT)) state <= SYNC_WAIT;
                       else cnt <= cnt + 10'd1;
                SYNC_WAIT: if (regs_load_done) begin
                    infer_start <= 1'b1;
                    state       <= INFER;
                end else if (expired) begin
                    err   <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                // A result_ack coinciding with infer_done is not seen here, so it is dropped.
                INFER: if (infer_done) begin
                    result_class <= infer_class;
                    result_valid <= 1'b1;
                    state        <= RESULT;
                end else if (expired) begin
                    err   <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                RESULT: if (result_ack) begin
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
